// File: rtl/uart_line_echo.sv
// Line-buffered UART echo engine. It collects rx bytes into a line, then replays the line
// through an optional case/reverse transform, followed by an optional CR LF suffix.
module uart_line_echo #(
    parameter int unsigned       DATA_W      = 8,
    parameter int unsigned       DEPTH       = 128,
    parameter logic [DATA_W-1:0] TERM_CHAR   = DATA_W'(8'h0A),
    parameter int unsigned       TIMEOUT_CYC = 43_400,
    parameter bit                APPEND_CRLF = 1'b1
) (
    input  logic                       sys_clk,
    input  logic                       sys_rst,
    input  logic [1:0]                 mode,
    input  logic [DATA_W-1:0]          rx_data,
    input  logic                       rx_valid,
    output logic [DATA_W-1:0]          tx_data,
    output logic                       tx_valid,
    input  logic                       tx_ready,
    output logic [$clog2(DEPTH+1)-1:0] line_len,
    output logic                       line_done,
    output logic                       rx_drop,
    output logic                       busy
);
    localparam int unsigned       CNT_W     = $clog2(DEPTH + 1);
    localparam int unsigned       PTR_W     = $clog2(DEPTH);
    localparam int unsigned       IDLE_W    = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);
    localparam logic [CNT_W-1:0]  FULL      = CNT_W'(DEPTH);
    localparam logic [DATA_W-1:0] CR        = DATA_W'(8'h0D);
    localparam logic [DATA_W-1:0] LF        = DATA_W'(8'h0A);

    typedef enum logic [2:0] {S_RX, S_TX_BODY, S_TX_CR, S_TX_LF, S_DONE} state_t;
    state_t state, state_nx;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [CNT_W-1:0]  cnt, left, cnt_m1;
    logic [PTR_W-1:0]  rd_ptr;
    logic [IDLE_W-1:0] idle;
    logic [1:0]        mode_q;
    logic              in_rx, is_term, store, close, accept, load_body, body_last;

    function automatic logic [DATA_W-1:0] xform(input logic [DATA_W-1:0] b, input logic [1:0] m);
        logic [DATA_W-1:0] r;
        r = b;
        if (m == 2'd1 && b >= DATA_W'(8'h61) && b <= DATA_W'(8'h7A))
            r = b - DATA_W'(8'h20);
        else if (m == 2'd2 && b >= DATA_W'(8'h41) && b <= DATA_W'(8'h5A))
            r = b + DATA_W'(8'h20);
        return r;
    endfunction

    always_comb begin
        in_rx     = (state == S_RX);
        is_term   = rx_valid && (rx_data == TERM_CHAR);
        store     = in_rx && rx_valid && !is_term && (cnt != FULL);
        close     = in_rx && (is_term || (cnt == FULL) ||
                    ((TIMEOUT_CYC != 0) && (cnt != '0) && (idle == IDLE_LAST) && !rx_valid));
        accept    = tx_valid && tx_ready;
        // left counts body bytes still to be loaded; the last accept then hands over to CR
        load_body = (state == S_TX_BODY) && (!tx_valid || accept) && (left != '0);
        body_last = (state == S_TX_BODY) && accept && (left == '0);
        cnt_m1    = cnt - CNT_W'(1);
        line_done = (state == S_DONE);
        busy      = (state == S_TX_BODY) || (state == S_TX_CR) || (state == S_TX_LF);

        state_nx = state;
        case (state)
            S_RX: begin
                if (close) begin
                    if (cnt != '0)       state_nx = S_TX_BODY;
                    else if (APPEND_CRLF) state_nx = S_TX_CR;
                    else                 state_nx = S_DONE;
                end
            end
            S_TX_BODY: if (body_last) state_nx = APPEND_CRLF ? S_TX_CR : S_DONE;
            S_TX_CR:   if (accept) state_nx = S_TX_LF;
            S_TX_LF:   if (accept) state_nx = S_DONE;
            S_DONE:    state_nx = S_RX;
            default:   state_nx = S_RX;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) state <= S_RX;
        else         state <= state_nx;
    end

    always_ff @(posedge sys_clk) begin
        if (store) mem[cnt[PTR_W-1:0]] <= rx_data;
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            cnt      <= '0;
            left     <= '0;
            rd_ptr   <= '0;
            idle     <= '0;
            mode_q   <= '0;
            tx_data  <= '0;
            tx_valid <= 1'b0;
            line_len <= '0;
            rx_drop  <= 1'b0;
        end else begin
            rx_drop <= rx_valid && (!in_rx || (!is_term && cnt == FULL));
            if (store) begin
                cnt  <= cnt + CNT_W'(1);
                idle <= '0;
            end else if (in_rx && idle != IDLE_LAST) begin
                idle <= idle + IDLE_W'(1);
            end
            if (close) begin
                mode_q   <= mode;
                line_len <= cnt;
                left     <= cnt;
                rd_ptr   <= (mode == 2'd3) ? cnt_m1[PTR_W-1:0] : '0;
            end
            if (load_body) begin
                tx_data  <= xform(mem[rd_ptr], mode_q);
                tx_valid <= 1'b1;
                left     <= left - CNT_W'(1);
                rd_ptr   <= (mode_q == 2'd3) ? rd_ptr - PTR_W'(1) : rd_ptr + PTR_W'(1);
            end
            if (body_last) begin
                tx_data  <= CR;
                tx_valid <= APPEND_CRLF;
            end
            if (state == S_TX_CR) begin
                if (!tx_valid) begin
                    tx_data  <= CR;
                    tx_valid <= 1'b1;
                end else if (accept) begin
                    tx_data <= LF;
                end
            end
            if (state == S_TX_LF && accept) tx_valid <= 1'b0;
            if (state == S_DONE) begin
                cnt  <= '0;
                idle <= '0;
            end
        end
    end
endmodule

// File: tb/tb_uart_line_echo.sv
// Randomised line-level bench for uart_line_echo. Expected tx streams come from a string model:
// the line is transformed, optionally reversed, and CR LF is appended.
module tb_uart_line_echo;
    localparam int unsigned DEPTH = 8;
    localparam int unsigned TOUT  = 100;
    typedef logic [7:0] bq_t [$];

    logic                       sys_clk  = 1'b0;
    logic                       sys_rst  = 1'b1;
    logic [1:0]                 mode     = '0;
    logic [7:0]                 rx_data  = '0;
    logic                       rx_valid = 1'b0;
    logic [7:0]                 tx_data;
    logic                       tx_valid;
    logic                       tx_ready = 1'b0;
    logic [$clog2(DEPTH+1)-1:0] line_len;
    logic                       line_done;
    logic                       rx_drop;
    logic                       busy;

    uart_line_echo #(
        .DATA_W(8), .DEPTH(DEPTH), .TERM_CHAR(8'h0A), .TIMEOUT_CYC(TOUT), .APPEND_CRLF(1'b1)
    ) dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .mode(mode),
        .rx_data(rx_data), .rx_valid(rx_valid),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .line_len(line_len), .line_done(line_done), .rx_drop(rx_drop), .busy(busy)
    );

    always #5 sys_clk = ~sys_clk;

    int         n_cmp     = 0;
    int         n_mis     = 0;
    int         cyc       = 0;
    int         done_cnt  = 0;
    int         rdy_mode  = 0;  // 0 always ready, 1 toggling, 2 random, 3 held low
    int         first_acc = -1;
    int         last_acc  = -1;
    logic       stall_prev = 1'b0;
    logic [7:0] stall_data = '0;
    bq_t        got, exp_q, body, empty;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, req);
        end
    endtask

    // Mid-cycle monitor: records accepted bytes, line_done pulses and stall stability.
    initial begin
        forever begin
            @(negedge sys_clk);
            cyc++;
            if (stall_prev) begin
                check_eq("stall_valid", 32'(tx_valid), 32'd1);
                check_eq("stall_data", 32'(tx_data), 32'(stall_data));
            end
            stall_prev = tx_valid && !tx_ready && !sys_rst;
            stall_data = tx_data;
            if (!sys_rst && tx_valid && tx_ready) begin
                got.push_back(tx_data);
                if (first_acc < 0) first_acc = cyc;
                last_acc = cyc;
            end
            if (line_done) done_cnt++;
        end
    end

    task automatic tick();
        @(posedge sys_clk);
        #1;
        case (rdy_mode)
            0:       tx_ready = 1'b1;
            1:       tx_ready = ~tx_ready;
            2:       tx_ready = 1'($urandom_range(0, 1));
            default: tx_ready = 1'b0;
        endcase
    endtask

    function automatic void model(input bq_t line, input logic [1:0] m);
        exp_q.delete();
        for (int i = 0; i < line.size(); i++) begin
            logic [7:0] b;
            b = (m == 2'd3) ? line[line.size() - 1 - i] : line[i];
            if (m == 2'd1 && b inside {[8'h61:8'h7A]})      b = b - 8'h20;
            else if (m == 2'd2 && b inside {[8'h41:8'h5A]}) b = b + 8'h20;
            exp_q.push_back(b);
        end
        exp_q.push_back(8'h0D);
        exp_q.push_back(8'h0A);
    endfunction

    function automatic logic [7:0] rand_byte();
        logic [7:0] b;
        do begin
            if ($urandom_range(0, 1) == 1) b = 8'($urandom_range(8'h3F, 8'h7C));
            else                           b = 8'($urandom_range(0, 255));
        end while (b == 8'h0A);
        return b;
    endfunction

    task automatic drive_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
    endtask

    task automatic start_line(input logic [1:0] m, input bq_t line);
        got.delete();
        first_acc = -1;
        last_acc  = -1;
        model(line, m);
        mode = m;
    endtask

    task automatic collect(input int body_len, input bit inject);
        int start;
        int guard;
        bit dropped;
        start   = done_cnt;
        guard   = 0;
        dropped = 1'b0;
        while (done_cnt == start && guard < 3000) begin
            if (busy && inject && !dropped) begin
                dropped = 1'b1;
                drive_byte(8'h58);
                check_eq("rx_drop_pulse", 32'(rx_drop), 32'd1);
                tick();
                check_eq("rx_drop_clear", 32'(rx_drop), 32'd0);
                guard += 2;
            end else begin
                if (busy) mode = 2'($urandom_range(0, 3));
                tick();
                guard++;
            end
        end
        if (done_cnt == start) check_eq("line_done_timeout", 32'd0, 32'd1);
        check_eq("tx_count", 32'(got.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got.size(); i++)
            check_eq($sformatf("tx_byte%0d", i), 32'(got[i]), 32'(exp_q[i]));
        check_eq("line_len", 32'(line_len), 32'(body_len));
        if (rdy_mode == 0) check_eq("gapless_span", 32'(last_acc - first_acc), 32'(exp_q.size() - 1));
        tick();
        tick();
        check_eq("line_done_once", 32'(done_cnt - start), 32'd1);
        check_eq("idle_after_line", 32'(busy), 32'd0);
    endtask

    task automatic run_line(input bq_t line, input bit term, input logic [1:0] m, input bit inject);
        start_line(m, line);
        foreach (line[i]) begin
            drive_byte(line[i]);
            repeat ($urandom_range(0, 2)) tick();
        end
        if (term) drive_byte(8'h0A);
        collect(line.size(), inject);
    endtask

    initial begin
        repeat (3) tick();
        check_eq("rst_tx_valid", 32'(tx_valid), 32'd0);
        check_eq("rst_tx_data", 32'(tx_data), 32'd0);
        check_eq("rst_line_len", 32'(line_len), 32'd0);
        check_eq("rst_line_done", 32'(line_done), 32'd0);
        check_eq("rst_rx_drop", 32'(rx_drop), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        sys_rst = 1'b0;
        tick();

        rdy_mode = 0;
        body = {8'h61, 8'h62, 8'h63};
        run_line(body, 1'b1, 2'd0, 1'b0);

        rdy_mode = 1;
        body = {8'h48, 8'h69, 8'h39, 8'h7A};
        run_line(body, 1'b1, 2'd1, 1'b0);

        rdy_mode = 0;
        body = {8'h77, 8'h78, 8'h79, 8'h7A, 8'h61, 8'h62, 8'h63, 8'h64};
        run_line(body, 1'b0, 2'd3, 1'b0);

        body = {8'h6F, 8'h6B};
        start_line(2'd0, body);
        drive_byte(8'h6F);
        drive_byte(8'h6B);
        for (int j = 1; j <= TOUT; j++) begin
            tick();
            if (j == TOUT - 1) begin
                check_eq("timeout_early_busy", 32'(busy), 32'd0);
                check_eq("timeout_early_tx", 32'(got.size()), 32'd0);
            end
            if (j == TOUT) check_eq("timeout_fire_busy", 32'(busy), 32'd1);
        end
        collect(2, 1'b0);

        run_line(empty, 1'b1, 2'd0, 1'b0);

        rdy_mode = 1;
        body = {8'h61, 8'h62, 8'h63};
        run_line(body, 1'b1, 2'd0, 1'b1);
        body = {8'h64};
        run_line(body, 1'b1, 2'd0, 1'b0);

        rdy_mode = 3;
        tick();
        mode = 2'd0;
        drive_byte(8'h61);
        drive_byte(8'h62);
        drive_byte(8'h63);
        drive_byte(8'h0A);
        for (int g = 0; g < 20 && !tx_valid; g++) tick();
        check_eq("pre_reset_valid", 32'(tx_valid), 32'd1);
        sys_rst = 1'b1;
        tick();
        check_eq("mid_rst_tx_valid", 32'(tx_valid), 32'd0);
        check_eq("mid_rst_tx_data", 32'(tx_data), 32'd0);
        check_eq("mid_rst_busy", 32'(busy), 32'd0);
        check_eq("mid_rst_line_len", 32'(line_len), 32'd0);
        check_eq("mid_rst_line_done", 32'(line_done), 32'd0);
        sys_rst  = 1'b0;
        rdy_mode = 0;
        tick();
        body = {8'h71};
        run_line(body, 1'b1, 2'd0, 1'b0);

        for (int n = 0; n < 40; n++) begin
            int len;
            bit full;
            rdy_mode = $urandom_range(0, 2);
            full     = ($urandom_range(0, 4) == 0);
            len      = full ? int'(DEPTH) : int'($urandom_range(0, DEPTH - 1));
            body.delete();
            for (int i = 0; i < len; i++) body.push_back(rand_byte());
            run_line(body, !full, 2'($urandom_range(0, 3)), $urandom_range(0, 3) == 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule
